// File: rtl/bit_serial_pkg.sv
// Shared types and helpers for the bit-serial add/subtract engine.
//   state_t    : engine FSM encoding (IDLE -> RUN -> DONE -> IDLE)
//   cnt_width(): bit-counter width for a given operand width
package bit_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of bits needed to count 0..width-1. Never returns less than 1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fulladdersub_beh.sv
// One-bit full-adder cell, the only arithmetic in the bit-serial engine.
//   a, b, cin : operand bits and carry-in
//   s, c      : sum bit and carry-out
module fulladdersub_beh (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_addsub.sv
// Bit-serial WIDTH-bit add/subtract engine. Operands are accepted in parallel,
// processed LSB-first one bit per clock through a single full-adder cell with a
// carry flip-flop, and the result is returned in parallel.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake for {a, b, cin, sub}
//   a, b                : operands (unsigned or two's complement)
//   cin                 : carry-in for add, ignored for subtract
//   sub                 : 0 = a+b+cin, 1 = a-b (a + ~b + 1)
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : result, carry out of MSB (1 = no borrow), signed overflow
module bit_serial_addsub
  import bit_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t             state_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-1:0]   sum_sh_q;
  logic               carry_q;
  logic               c_msb_in_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;

  logic               fa_s;
  logic               fa_c;

  fulladdersub_beh u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .c   (fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      carry_q     <= 1'b0;
      c_msb_in_q  <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // in_ready is registered so it stays low through reset and rises
          // on the first edge after release.
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            a_sh_q     <= a;
            b_sh_q     <= sub ? ~b : b;
            carry_q    <= sub ? 1'b1 : cin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= {fa_s, sum_sh_q[WIDTH-1:1]};
          carry_q  <= fa_c;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            // carry_q still holds the carry into the MSB on this last bit
            c_msb_in_q <= carry_q;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          // First DONE cycle publishes the result; it is then held until taken.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            sum_q       <= sum_sh_q;
            cout_q      <= carry_q;
            ovf_q       <= c_msb_in_q ^ carry_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
